// File: rtl/mdio_pkg.sv
// MDIO command-word field constants, bit positions, sequencer state encoding and the
// command-word builder shared by the configuration sequencer.
package mdio_pkg;

    localparam logic [1:0] MDIO_ST    = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b10;
    localparam logic [1:0] MDIO_OP_RD = 2'b01;
    localparam logic [1:0] MDIO_TA    = 2'b01;

    localparam int unsigned CMD_DATA_LSB = 16;
    localparam int unsigned CMD_TA_LSB   = 14;
    localparam int unsigned CMD_REG_LSB  = 9;
    localparam int unsigned CMD_PHY_LSB  = 4;
    localparam int unsigned CMD_OP_LSB   = 2;
    localparam int unsigned CMD_ST_LSB   = 0;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_NEXT      = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;
    localparam logic [2:0] ST_ERR       = 3'd7;

    typedef enum logic [2:0] {
        StIdle     = ST_IDLE,
        StFetch    = ST_FETCH,
        StIssue    = ST_ISSUE,
        StWaitAck  = ST_WAIT_ACK,
        StWaitDone = ST_WAIT_DONE,
        StNext     = ST_NEXT,
        StDone     = ST_DONE,
        StErr      = ST_ERR
    } seq_state_e;

    function automatic logic [31:0] mdio_cmd(input logic [15:0] data, input logic [4:0] regad,
                                             input logic [4:0] phy, input logic [1:0] op);
        logic [31:0] cmd;
        cmd                     = '0;
        cmd[CMD_DATA_LSB +: 16] = data;
        cmd[CMD_TA_LSB +: 2]    = MDIO_TA;
        cmd[CMD_REG_LSB +: 5]   = regad;
        cmd[CMD_PHY_LSB +: 5]   = phy;
        cmd[CMD_OP_LSB +: 2]    = op;
        cmd[CMD_ST_LSB +: 2]    = MDIO_ST;
        return cmd;
    endfunction

endpackage

// File: rtl/mdio_cfg_rom.sv
// Default PHY register image (index -> 16-bit value), registered output. Meant to be wired
// alongside the sequencer: o_tbl_idx -> i_idx, o_data -> i_tbl_data.
module mdio_cfg_rom (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [4:0]  i_idx,
    output logic [15:0] o_data
);

    logic [15:0] rom_val;

    always_comb begin
        rom_val = 16'h0000;
        case (i_idx)
            5'd0:  rom_val = 16'h1140;
            5'd1:  rom_val = 16'h7949;
            5'd2:  rom_val = 16'h0141;
            5'd3:  rom_val = 16'h0cc2;
            5'd4:  rom_val = 16'h01e1;
            5'd6:  rom_val = 16'h0004;
            5'd7:  rom_val = 16'h2001;
            5'd9:  rom_val = 16'h0e00;
            5'd15: rom_val = 16'h3000;
            5'd16: rom_val = 16'h0078;
            5'd17: rom_val = 16'h8110;
            5'd20: rom_val = 16'h0c68;
            5'd24: rom_val = 16'h4100;
            5'd26: rom_val = 16'h000a;
            5'd27: rom_val = 16'h848b;
            default: rom_val = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data <= 16'h0000;
        end else begin
            o_data <= rom_val;
        end
    end

endmodule

// File: rtl/mdio_cfg_sequencer.sv
// Writes a PHY register table through the MDIO master's command interface and, when
// MDIO_CFG_VERIFY_EN is defined, reads every register back and counts mismatches.
module mdio_cfg_sequencer
    import mdio_pkg::*;
#(
    parameter int unsigned N_REGS      = 32,
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    output logic [4:0]  o_tbl_idx,
    input  logic [15:0] i_tbl_data,
    output logic        o_new_cmd,
    output logic [31:0] o_cmd,
    input  logic        i_rdy,
    input  logic        i_rd_valid,
    input  logic [15:0] i_rd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [5:0]  o_mismatch_cnt,
    output logic [4:0]  o_first_bad_idx
);

    localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
    localparam logic [4:0]      LastIdx = 5'(N_REGS - 1);

    seq_state_e      state_q;
    logic            fetch_ph_q, pass_rd_q;
    logic [4:0]      idx_q;
    logic [15:0]     entry_q;
    logic [31:0]     cmd_q;
    logic            new_cmd_q, busy_q, done_q, error_q;
    logic [TmoW-1:0] tmo_q;
    logic            counting, progress, tmo_hit;

`ifdef MDIO_CFG_VERIFY_EN
    logic [5:0]  mm_cnt_q;
    logic [4:0]  first_bad_q;
    logic        rd_seen_q;
    logic [15:0] rd_data_q;
    logic        mm_hit;

    // A read that completed without any data strobe is also a mismatch.
    assign mm_hit          = pass_rd_q && (!rd_seen_q || (rd_data_q != entry_q));
    assign o_mismatch_cnt  = mm_cnt_q;
    assign o_first_bad_idx = first_bad_q;
`else
    logic unused_rd;
    assign unused_rd       = ^{i_rd_valid, i_rd_data};
    assign o_mismatch_cnt  = 6'd0;
    assign o_first_bad_idx = 5'd0;
`endif

    always_comb begin
        progress = 1'b0;
        case (state_q)
            StIssue:    progress = i_rdy;
            StWaitAck:  progress = !i_rdy;
            StWaitDone: progress = i_rdy;
            default:    progress = 1'b0;
        endcase
    end

    assign counting = (state_q == StIssue) || (state_q == StWaitAck) || (state_q == StWaitDone);
    assign tmo_hit  = (tmo_q == TmoLast);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            fetch_ph_q  <= 1'b0;
            pass_rd_q   <= 1'b0;
            idx_q       <= 5'd0;
            entry_q     <= 16'h0000;
            cmd_q       <= 32'h0;
            new_cmd_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            tmo_q       <= '0;
`ifdef MDIO_CFG_VERIFY_EN
            mm_cnt_q    <= 6'd0;
            first_bad_q <= 5'd0;
            rd_seen_q   <= 1'b0;
            rd_data_q   <= 16'h0000;
`endif
        end else begin
            new_cmd_q <= 1'b0;
            tmo_q     <= '0;
            case (state_q)
                StIdle: begin
                    if (i_start) begin
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
`ifdef MDIO_CFG_VERIFY_EN
                        mm_cnt_q    <= 6'd0;
                        first_bad_q <= 5'd0;
`endif
                        idx_q       <= 5'd0;
                        pass_rd_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        fetch_ph_q  <= 1'b0;
                        state_q     <= StFetch;
                    end
                end
                // The table output is registered on o_tbl_idx, so it settles one cycle late.
                StFetch: begin
                    fetch_ph_q <= ~fetch_ph_q;
                    if (fetch_ph_q) begin
                        entry_q <= i_tbl_data;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (i_rdy) begin
                        cmd_q     <= mdio_cmd(pass_rd_q ? 16'h0000 : entry_q, idx_q, PHY_ADDR,
                                              pass_rd_q ? MDIO_OP_RD : MDIO_OP_WR);
                        new_cmd_q <= 1'b1;
`ifdef MDIO_CFG_VERIFY_EN
                        rd_seen_q <= 1'b0;
`endif
                        state_q   <= StWaitAck;
                    end
                end
                StWaitAck, StWaitDone: begin
`ifdef MDIO_CFG_VERIFY_EN
                    if (pass_rd_q && i_rd_valid) begin
                        rd_data_q <= i_rd_data;
                        rd_seen_q <= 1'b1;
                    end
`endif
                    if (progress) begin
                        state_q <= (state_q == StWaitAck) ? StWaitDone : StNext;
                    end
                end
                StNext: begin
`ifdef MDIO_CFG_VERIFY_EN
                    if (mm_hit) begin
                        if (mm_cnt_q != 6'd32) mm_cnt_q <= mm_cnt_q + 6'd1;
                        if (mm_cnt_q == 6'd0) first_bad_q <= idx_q;
                    end
`endif
                    if (idx_q != LastIdx) begin
                        idx_q   <= idx_q + 5'd1;
                        state_q <= StFetch;
`ifdef MDIO_CFG_VERIFY_EN
                    end else if (!pass_rd_q) begin
                        pass_rd_q <= 1'b1;
                        idx_q     <= 5'd0;
                        state_q   <= StFetch;
`endif
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
`ifdef MDIO_CFG_VERIFY_EN
                        error_q <= (mm_cnt_q != 6'd0) || mm_hit;
`endif
                        state_q <= StDone;
                    end
                end
                StDone, StErr: state_q <= StIdle;
                default:       state_q <= StIdle;
            endcase

            if (counting && !progress) begin
                if (tmo_hit) begin
                    error_q <= 1'b1;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StErr;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    assign o_tbl_idx = idx_q;
    assign o_new_cmd = new_cmd_q;
    assign o_cmd     = cmd_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_error   = error_q;

endmodule

// File: tb/tb_mdio_cfg_sequencer.sv
// Bench for mdio_cfg_sequencer with the default register ROM and a randomized MDIO master model.
// Honours MDIO_CFG_VERIFY_EN the same way the design does.
module tb_mdio_cfg_sequencer;

    localparam int unsigned N   = 32;
    localparam logic [4:0]  PHY = 5'd0;
    localparam int unsigned TMO = 4096;
`ifdef MDIO_CFG_VERIFY_EN
    localparam bit Verify = 1'b1;
`else
    localparam bit Verify = 1'b0;
`endif
    localparam int NCmd = Verify ? 2 * N : N;

    logic        clk, rst, start, new_cmd, rdy, rd_valid, busy, done, error;
    logic [4:0]  tbl_idx, first_bad;
    logic [15:0] tbl_data, rd_data;
    logic [31:0] cmd;
    logic [5:0]  mm_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected register image for the default ROM.
    logic [15:0] tbl [32] = '{
        16'h1140, 16'h7949, 16'h0141, 16'h0cc2, 16'h01e1, 16'h0000, 16'h0004, 16'h2001,
        16'h0000, 16'h0e00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3000,
        16'h0078, 16'h8110, 16'h0000, 16'h0000, 16'h0c68, 16'h0000, 16'h0000, 16'h0000,
        16'h4100, 16'h0000, 16'h000a, 16'h848b, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    // Master model state.
    logic [31:0] cmds [$];
    logic [15:0] phy_mem [32];
    logic [31:0] zero_mask, flip_mask, novalid_mask;
    int unsigned lat, hang_after;
    bit          early, cur_rd;
    logic [4:0]  cur_reg;
    int          strobe_bad;

    mdio_cfg_rom u_rom (
        .i_clk   (clk),
        .i_reset (rst),
        .i_idx   (tbl_idx),
        .o_data  (tbl_data)
    );

    mdio_cfg_sequencer #(
        .N_REGS      (N),
        .PHY_ADDR    (PHY),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_start         (start),
        .o_tbl_idx       (tbl_idx),
        .i_tbl_data      (tbl_data),
        .o_new_cmd       (new_cmd),
        .o_cmd           (cmd),
        .i_rdy           (rdy),
        .i_rd_valid      (rd_valid),
        .i_rd_data       (rd_data),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error),
        .o_mismatch_cnt  (mm_cnt),
        .o_first_bad_idx (first_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Command k of a run: writes of the table in register order, then reads in the same order.
    function automatic logic [31:0] exp_cmd(input int k);
        int          r;
        bit          rd;
        logic [31:0] d;
        rd = (k >= int'(N));
        r  = rd ? k - int'(N) : k;
        d  = rd ? 32'd0 : 32'(tbl[r]);
        return d * 32'd65536 + 32'h4000 + 32'(r) * 32'd512 + 32'(PHY) * 32'd16
               + (rd ? 32'd4 : 32'd8) + 32'd2;
    endfunction

    // Randomized master: busy 2..5 cycles per command, read data with or just before ready.
    initial begin
        rdy = 1'b1; rd_valid = 1'b0; rd_data = 16'h0; lat = 0; strobe_bad = 0;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (rst) begin
                rdy = 1'b1;
                lat = 0;
            end else if (new_cmd) begin
                cmds.push_back(cmd);
                if (!rdy) strobe_bad++;
                cur_reg = cmd[13:9];
                cur_rd  = (cmd[3:2] == 2'b01);
                if (!cur_rd) phy_mem[cur_reg] = cmd[31:16];
                rdy   = 1'b0;
                lat   = $urandom_range(5, 2);
                early = 1'($urandom_range(1, 0));
                if (hang_after != 0 && cmds.size() == int'(hang_after)) lat = 0;
            end else if (!rdy && lat > 0) begin
                lat--;
                if (cur_rd && !novalid_mask[cur_reg] && (early ? lat == 1 : lat == 0)) begin
                    rd_valid = 1'b1;
                    rd_data  = zero_mask[cur_reg] ? 16'h0000 :
                               flip_mask[cur_reg] ? ~phy_mem[cur_reg] : phy_mem[cur_reg];
                end
                if (lat == 0) rdy = 1'b1;
            end
        end
    end

    task automatic check_idle_zero(input string tag);
        check({tag, "_new_cmd"}, new_cmd, 0);
        check({tag, "_cmd"}, cmd, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_idx"}, tbl_idx, 0);
        check({tag, "_mm"}, mm_cnt, 0);
        check({tag, "_first"}, first_bad, 0);
    endtask

    // One full sequence; optionally pokes i_start while busy and on the DONE cycle.
    task automatic run_seq(input bit poke);
        int cyc;
        bit seen;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc  = 0;
        seen = 0;
        while (cyc < 20000 && !seen) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 40) begin
                check("busy_at_poke", busy, 1);
                start = 1'b1;
            end else if (poke && cyc == 41) begin
                start = 1'b0;
            end
            if (done) seen = 1;
        end
        check("done_in_budget", seen, 1);
        if (poke) begin
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        repeat (20) @(negedge clk);
        #1;
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_ncmd"}, cmds.size(), NCmd);
        for (int i = 0; i < cmds.size() && i < NCmd; i++) check({tag, "_cmd"}, cmds[i], exp_cmd(i));
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 1);
    endtask

    initial begin
        int          strobes, t5, te, cyc, cnt, first;
        bit          found;
        logic [31:0] bad;
        rst = 1'b1; start = 1'b0; hang_after = 0;
        zero_mask = '0; flip_mask = '0; novalid_mask = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean run with start pokes that must be ignored.
        cmds.delete();
        run_seq(1'b1);
        check("first_cmd", cmds.size() > 0 ? cmds[0] : 32'hx, 32'h1140_400A);
        check_seq("clean");
        check("clean_error", error, 0);
        check("clean_mm", mm_cnt, 0);
        check("strobe_while_busy", strobe_bad, 0);

        // Registers 3 and 17 read back as zero.
        cmds.delete();
        zero_mask = (32'd1 << 3) | (32'd1 << 17);
        run_seq(1'b0);
        check_seq("corrupt");
        check("corrupt_mm", mm_cnt, Verify ? 2 : 0);
        check("corrupt_first", first_bad, Verify ? 3 : 0);
        check("corrupt_error", error, Verify ? 1 : 0);
        zero_mask = '0;

        // Random corrupted and missing read data.
        for (int it = 0; it < 3; it++) begin
            cmds.delete();
            flip_mask    = $urandom;
            novalid_mask = $urandom & $urandom;
            bad   = flip_mask | novalid_mask;
            cnt   = 0;
            first = 0;
            found = 0;
            for (int i = 0; i < int'(N); i++) begin
                if (bad[i]) begin
                    cnt++;
                    if (!found) begin
                        first = i;
                        found = 1;
                    end
                end
            end
            run_seq(1'b0);
            check_seq("rand");
            check("rand_mm", mm_cnt, Verify ? cnt : 0);
            check("rand_first", first_bad, Verify ? first : 0);
            check("rand_error", error, (Verify && cnt != 0) ? 1 : 0);
        end
        flip_mask = '0;
        novalid_mask = '0;

        // Master stalls after the 5th command; accepted one cycle after its strobe.
        cmds.delete();
        hang_after = 5;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        strobes = 0; t5 = -1; te = -1; cyc = 0;
        while (te < 0 && cyc < int'(TMO) + 2000) begin
            @(negedge clk);
            cyc++;
            if (new_cmd) begin
                strobes++;
                if (strobes == 5) t5 = cyc;
            end
            if (error) te = cyc;
        end
        check("tmo_latency", te - t5, TMO + 1);
        check("tmo_done", done, 1);
        check("tmo_busy", busy, 0);
        repeat (20) begin
            @(negedge clk);
            if (new_cmd) strobes++;
        end
        check("tmo_strobes", strobes, 5);
        check("tmo_error_held", error, 1);
        hang_after = 0;
        rst = 1'b1;
        #1;
        check_idle_zero("post_tmo_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during command 10, then a full restart.
        cmds.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        strobes = 0; cyc = 0;
        while (strobes < 10 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (new_cmd) strobes++;
        end
        check("reach_cmd10", strobes, 10);
        rst = 1'b1;
        #1;
        check_idle_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        cmds.delete();
        run_seq(1'b0);
        check_seq("restart");
        check("restart_error", error, 0);
        check("restart_mm", mm_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
